// File: rtl/imm_gen_pipe_pkg.sv
// Shared definitions for the immediate generator family.
// Build option: define IMM_CSR_EN to add the CSR zimm format. This widens the
// one-hot ext_op word from 6 to 7 bits, and the six legacy codes gain a leading 0.
package imm_gen_pipe_pkg;

    // Default datapath width. Legal values are 32 and 64.
    localparam int XLEN_DEFAULT = 32;

`ifdef IMM_CSR_EN
    localparam int EXT_OP_W = 7;
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_CSR = 7'b1000000;
`else
    localparam int EXT_OP_W = 6;
`endif

    // One-hot format selects. Zero-extending from six bits supplies the
    // leading 0 that these codes carry in the CSR-enabled build.
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_SHAMT = EXT_OP_W'(6'b100000);
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_I     = EXT_OP_W'(6'b010000);
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_S     = EXT_OP_W'(6'b001000);
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_B     = EXT_OP_W'(6'b000100);
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_U     = EXT_OP_W'(6'b000010);
    localparam logic [EXT_OP_W-1:0] EXT_CTRL_J     = EXT_OP_W'(6'b000001);

endpackage

// File: rtl/imm_gen_pipe_extract.sv
// imm_extract: a purely combinational slice that maps an instruction and its
// one-hot format select to an XLEN immediate. It is shared with the
// single-cycle core.
// Build option: IMM_CSR_EN adds the CSR zimm format (instr[19:15], zero-extended).
module imm_extract
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int EXT_W = EXT_OP_W
) (
    input  logic [31:0]      instr,
    input  logic [EXT_W-1:0] ext_op,
    output logic [XLEN-1:0]  imm,
    output logic             err
);

    logic [31:0] raw;
    logic        sign_ext;
    logic        unused_opcode;

    // The opcode field never contributes to an immediate.
    assign unused_opcode = ^instr[6:0];

    // Gather the format's bits into a 32-bit field. Then sign-extend or
    // zero-extend that field to XLEN. An illegal select yields 0 and raises err.
    always_comb begin
        raw      = 32'd0;
        sign_ext = 1'b0;
        err      = 1'b0;
        case (ext_op)
            EXT_CTRL_SHAMT: begin
                if (XLEN == 64) raw = {26'd0, instr[25:20]};
                else            raw = {27'd0, instr[24:20]};
            end
            EXT_CTRL_I: begin
                raw      = {{20{instr[31]}}, instr[31:20]};
                sign_ext = 1'b1;
            end
            EXT_CTRL_S: begin
                raw      = {{20{instr[31]}}, instr[31:25], instr[11:7]};
                sign_ext = 1'b1;
            end
            EXT_CTRL_B: begin
                raw      = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
                sign_ext = 1'b1;
            end
            EXT_CTRL_U: begin
                raw      = {instr[31:12], 12'd0};
                sign_ext = 1'b1;
            end
            EXT_CTRL_J: begin
                raw      = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
                sign_ext = 1'b1;
            end
`ifdef IMM_CSR_EN
            EXT_CTRL_CSR: begin
                raw = {27'd0, instr[19:15]};
            end
`endif
            default: begin
                err = 1'b1;
            end
        endcase
    end

    // Widen the 32-bit field to the datapath width.
    always_comb begin
        if (sign_ext) imm = XLEN'($signed(raw));
        else          imm = XLEN'(raw);
    end

endmodule

// File: rtl/imm_gen_pipe.sv
// imm_gen_pipe: a two-stage pipelined immediate generator with a PC-relative
// target adder. It uses valid/ready handshakes on both sides.
// Stage 1 registers the extracted immediate, the PC and the error flag.
// Stage 2 registers imm, pc + imm and imm_err onto the outputs.
// Build option: IMM_CSR_EN (7-bit ext_op with the CSR zimm format).
module imm_gen_pipe
    import imm_gen_pipe_pkg::*;
#(
    parameter int XLEN  = XLEN_DEFAULT,
    parameter int EXT_W = EXT_OP_W
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             flush,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      instr,
    input  logic [EXT_W-1:0] ext_op,
    input  logic [XLEN-1:0]  pc,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [XLEN-1:0]  imm,
    output logic [XLEN-1:0]  target,
    output logic             imm_err
);

    logic            s1_valid_q, s1_valid_d;
    logic [XLEN-1:0] s1_imm_q,   s1_imm_d;
    logic [XLEN-1:0] s1_pc_q,    s1_pc_d;
    logic            s1_err_q,   s1_err_d;
    logic            out_valid_q, out_valid_d;
    logic [XLEN-1:0] imm_q,      imm_d;
    logic [XLEN-1:0] target_q,   target_d;
    logic            err_q,      err_d;

    logic [XLEN-1:0] ext_imm;
    logic            ext_err;
    logic            stage2_load;
    logic            stage1_load;
    logic            accept;

    imm_extract #(
        .XLEN  (XLEN),
        .EXT_W (EXT_W)
    ) u_extract (
        .instr  (instr),
        .ext_op (ext_op),
        .imm    (ext_imm),
        .err    (ext_err)
    );

    // The pipeline advances when the slot ahead is empty or is draining.
    // in_ready does not depend on in_valid.
    always_comb begin
        stage2_load = !out_valid_q || out_ready;
        stage1_load = !s1_valid_q || stage2_load;
        in_ready    = rstn && stage1_load;
        accept      = in_valid && in_ready;
    end

    // Next-state logic for both stages. Data registers load only when a valid
    // item moves in, so held outputs stay stable. Flush clears both valids.
    always_comb begin
        s1_valid_d  = s1_valid_q;
        s1_imm_d    = s1_imm_q;
        s1_pc_d     = s1_pc_q;
        s1_err_d    = s1_err_q;
        out_valid_d = out_valid_q;
        imm_d       = imm_q;
        target_d    = target_q;
        err_d       = err_q;

        if (stage2_load) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                imm_d    = s1_imm_q;
                target_d = s1_pc_q + s1_imm_q;
                err_d    = s1_err_q;
            end
        end

        if (stage1_load) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_imm_d = ext_imm;
                s1_pc_d  = pc;
                s1_err_d = ext_err;
            end
        end

        if (flush) begin
            s1_valid_d  = 1'b0;
            out_valid_d = 1'b0;
        end
    end

    // Stage registers. Reset is synchronous and takes priority over flush.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            s1_valid_q  <= 1'b0;
            s1_imm_q    <= '0;
            s1_pc_q     <= '0;
            s1_err_q    <= 1'b0;
            out_valid_q <= 1'b0;
            imm_q       <= '0;
            target_q    <= '0;
            err_q       <= 1'b0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            s1_imm_q    <= s1_imm_d;
            s1_pc_q     <= s1_pc_d;
            s1_err_q    <= s1_err_d;
            out_valid_q <= out_valid_d;
            imm_q       <= imm_d;
            target_q    <= target_d;
            err_q       <= err_d;
        end
    end

    // Drive the output ports from the stage-2 registers.
    always_comb begin
        out_valid = out_valid_q;
        imm       = imm_q;
        target    = target_q;
        imm_err   = err_q;
    end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Directed testbench for imm_gen_pipe. It runs a 32-bit and a 64-bit instance
// side by side on shared stimulus. Expected values are worked out by hand.
// Build option: IMM_CSR_EN adds the CSR zimm vector.
module tb_imm_gen_pipe;
    import imm_gen_pipe_pkg::*;

    logic                clk = 1'b0;
    logic                rstn;
    logic                flush;
    logic                in_valid;
    logic                out_ready;
    logic [31:0]         instr;
    logic [EXT_OP_W-1:0] ext_op;
    logic [31:0]         pc;
    logic [63:0]         pc64;

    logic                in_ready, out_valid, imm_err;
    logic [31:0]         imm, target;
    logic                in_ready64, out_valid64, imm_err64;
    logic [63:0]         imm64, target64;

    int total = 0;
    int bad   = 0;
    int sent;
    int got;
    logic seen;

    always #5 clk = ~clk;

    assign pc64 = {32'd0, pc};

    imm_gen_pipe #(.XLEN(32)) u_dut32 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready),
        .instr(instr), .ext_op(ext_op), .pc(pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .imm(imm), .target(target), .imm_err(imm_err)
    );

    imm_gen_pipe #(.XLEN(64)) u_dut64 (
        .clk(clk), .rstn(rstn), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready64),
        .instr(instr), .ext_op(ext_op), .pc(pc64),
        .out_valid(out_valid64), .out_ready(out_ready),
        .imm(imm64), .target(target64), .imm_err(imm_err64)
    );

    // Compare one observed value with its expected value and count the result.
    task automatic checkOutput(input string tag, input logic [63:0] got_v, input logic [63:0] exp_v);
        total++;
        if (got_v !== exp_v) begin
            bad++;
            $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", tag, got_v, exp_v);
        end
    endtask

    // Send one item with no backpressure and check it two edges later.
    task automatic applyStimulus(input string tag, input logic [31:0] i_instr,
                                 input logic [EXT_OP_W-1:0] i_op, input logic [31:0] i_pc,
                                 input logic [31:0] e_imm, input logic [31:0] e_tgt,
                                 input logic e_err, input logic [63:0] e_imm64);
        @(negedge clk);
        instr = i_instr; ext_op = i_op; pc = i_pc; in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput({tag, ".early"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        checkOutput({tag, ".valid"},  64'(out_valid), 64'd1);
        checkOutput({tag, ".imm"},    64'(imm),       64'(e_imm));
        checkOutput({tag, ".target"}, 64'(target),    64'(e_tgt));
        checkOutput({tag, ".err"},    64'(imm_err),   64'(e_err));
        checkOutput({tag, ".imm64"},  imm64,          e_imm64);
    endtask

    initial begin
        rstn = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        instr = 32'd0; ext_op = EXT_CTRL_I; pc = 32'd0;

        // Hold reset for two edges, then check the reset state.
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst.valid",    64'(out_valid), 64'd0);
        checkOutput("rst.imm",      64'(imm),       64'd0);
        checkOutput("rst.target",   64'(target),    64'd0);
        checkOutput("rst.in_ready", 64'(in_ready),  64'd0);
        rstn = 1'b1;

        applyStimulus("itype", 32'hFFF00093, EXT_CTRL_I, 32'h0,
                      32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFFFFFFFFFF);
        applyStimulus("btype", 32'hFE000EE3, EXT_CTRL_B, 32'h100,
                      32'hFFFFFFFC, 32'h000000FC, 1'b0, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus("jtype", 32'h0080006F, EXT_CTRL_J, 32'h100,
                      32'h8, 32'h108, 1'b0, 64'h8);
        applyStimulus("utype", 32'h80000037, EXT_CTRL_U, 32'h0,
                      32'h80000000, 32'h80000000, 1'b0, 64'hFFFFFFFF80000000);
        applyStimulus("shamt", 32'h03F01013, EXT_CTRL_SHAMT, 32'h10,
                      32'h1F, 32'h2F, 1'b0, 64'h3F);
        applyStimulus("stype", 32'hFE112E23, EXT_CTRL_S, 32'h20,
                      32'hFFFFFFFC, 32'h1C, 1'b0, 64'hFFFFFFFFFFFFFFFC);
        applyStimulus("illegal", 32'hFFF00093, EXT_OP_W'(6'b000011), 32'h40,
                      32'h0, 32'h40, 1'b1, 64'h0);

        // Backpressure: four I-types, with out_ready low for the first five cycles.
        @(negedge clk);
        sent = 0; got = 0;
        for (int c = 0; c < 40 && got < 4; c++) begin
            @(negedge clk);
            out_ready = (c >= 5);
            in_valid  = (sent < 4);
            instr     = {12'(sent + 1), 20'h00093};
            ext_op    = EXT_CTRL_I;
            pc        = 32'h0;
            #1;
            if (c == 2) begin
                checkOutput("bp.accepts",  64'(sent),     64'd2);
                checkOutput("bp.in_ready", 64'(in_ready), 64'd0);
            end
            if (c >= 2 && c < 5) begin
                checkOutput($sformatf("bp.hold%0d", c),  64'(imm),       64'd1);
                checkOutput($sformatf("bp.holdv%0d", c), 64'(out_valid), 64'd1);
            end
            if (out_valid && out_ready) begin
                checkOutput($sformatf("bp.order%0d", got), 64'(imm), 64'(got + 1));
                got++;
            end
            if (in_valid && in_ready) sent++;
        end
        in_valid = 1'b0;
        checkOutput("bp.delivered", 64'(got), 64'd4);
        @(negedge clk);
        checkOutput("bp.no_dup", 64'(out_valid), 64'd0);

        // Flush with both stages full and a third item offered.
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00500093;
        @(negedge clk);
        instr = 32'h00600093;
        @(negedge clk);
        instr = 32'h00700093; flush = 1'b1;
        #1;
        checkOutput("fl.full", 64'(out_valid), 64'd1);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checkOutput("fl.valid",    64'(out_valid), 64'd0);
        checkOutput("fl.in_ready", 64'(in_ready),  64'd1);
        seen = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            seen = seen | out_valid;
        end
        checkOutput("fl.none_out", 64'(seen), 64'd0);

        // Reset asserted while an item is stalled at the output.
        out_ready = 1'b0; in_valid = 1'b1; instr = 32'h00900093; pc = 32'h40;
        @(negedge clk);
        instr = 32'h00A00093;
        @(negedge clk);
        in_valid = 1'b0;
        checkOutput("mr.before", 64'(target), 64'h49);
        rstn = 1'b0;
        @(negedge clk);
        checkOutput("mr.valid",  64'(out_valid), 64'd0);
        checkOutput("mr.imm",    64'(imm),       64'd0);
        checkOutput("mr.target", 64'(target),    64'd0);
        checkOutput("mr.err",    64'(imm_err),   64'd0);
        checkOutput("mr.imm64",  imm64,          64'd0);
        rstn = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        checkOutput("mr.in_ready", 64'(in_ready),  64'd1);
        checkOutput("mr.empty",    64'(out_valid), 64'd0);

`ifdef IMM_CSR_EN
        applyStimulus("csr", 32'h000FD073, EXT_CTRL_CSR, 32'h0,
                      32'h1F, 32'h1F, 1'b0, 64'h1F);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/imm_gen_pipe.md
Name: imm_gen_pipe

Overview:
- Parametrised, two-stage pipelined immediate generator for the pipelined RISC-V core; successor to the single-cycle combinational extender.
- Takes the raw 32-bit instruction plus the one-hot EXT control word and extracts and extends the immediate to XLEN.
- Also computes the PC-relative target (pc + imm) in stage 2.
- Uses valid/ready handshakes on both sides so decode stalls and flushes are absorbed locally.

Parameters:
- XLEN, 32, datapath width; legal values are 32 or 64.
- EXT_W, 6, EXTOp width. Fixed at 6 without the optional feature; set to 7 when IMM_CSR_EN is defined.

Ports:
- clk  input  1  core clock, rising edge.
- rstn  input  1  reset, synchronous, active-low.
- flush  input  1  synchronous kill of both stages.
- in_valid  input  1  upstream request valid.
- in_ready  output  1  block can accept this cycle.
- instr  input  32  raw instruction word.
- ext_op  input  EXT_W  one-hot immediate format select.
- pc  input  XLEN  PC of the instruction.
- out_valid  output  1  result valid.
- out_ready  input  1  downstream accepts.
- imm  output  XLEN  extended immediate.
- target  output  XLEN  pc + imm, modulo 2^XLEN.
- imm_err  output  1  ext_op was not a legal one-hot code.

Behaviour:
- ext_op encodings:
  - SHAMT 6'b100000
  - I 6'b010000
  - S 6'b001000
  - B 6'b000100
  - U 6'b000010
  - J 6'b000001
- Immediate extraction, stage 1:
  - SHAMT: zero-extend instr[24:20] when XLEN=32; zero-extend instr[25:20] when XLEN=64.
  - I: sign-extend instr[31:20].
  - S: sign-extend {instr[31:25], instr[11:7]}.
  - B: sign-extend {instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}.
  - U: {instr[31:12], 12'b0}, sign-extended from bit 31 to XLEN.
  - J: sign-extend {instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}.
  - Zero or multi-hot ext_op: imm = 0, imm_err = 1.
- Stage 1 register holds imm, pc and err.
- Stage 2 computes target = s1_pc + s1_imm and registers imm, target and imm_err onto the outputs.
- Latency is exactly 2 cycles from the accept edge to out_valid when there is no backpressure. Throughput is 1 per cycle.
- Handshake:
  - Transfer in on in_valid & in_ready; transfer out on out_valid & out_ready.
  - Stage 2 loads when !out_valid | out_ready.
  - Stage 1 loads when !s1_valid | (stage 2 loads).
  - in_ready = rstn & (!s1_valid | stage-2-loads). This is combinational and carries no in_valid dependency.
  - Outputs stay stable while out_valid & !out_ready.
- Flush:
  - On the edge where flush=1, s1_valid and out_valid clear.
  - A concurrent in_valid is dropped.
  - Data registers are don't-care after flush.
  - in_ready=1 on the following cycle.
- Reset: with rstn low at an edge, all valids, imm, target and imm_err become 0. This applies mid-transfer too; in-flight data is lost. Reset has priority over flush.
- Arithmetic: target wraps modulo 2^XLEN with no overflow flag.

Optional Feature:
- Macro IMM_CSR_EN.
- When defined:
  - EXT_W=7.
  - Bit 6 (7'b1000000) selects CSR zimm: zero-extend instr[19:15].
  - The six legacy codes gain a leading 0.
- When undefined:
  - EXT_W=6 and no CSR code exists.
  - Any value outside the six codes sets imm_err.

Decomposition:
- Shared package/header: EXT_CTRL_* one-hot constants (including EXT_CTRL_CSR under the macro), XLEN default, EXT_W derivation.
- One sub-module: imm_extract, a purely combinational instr+ext_op to imm/err slice. It is reused by the single-cycle core and instantiated in stage 1 here.
- Handshake and stage registers stay in imm_gen_pipe.

Test Plan:
- I-type: instr=0xFFF00093, ext_op=I, pc=0x0 -> out_valid after 2 cycles, imm=0xFFFFFFFF, target=0xFFFFFFFF, imm_err=0.
- B-type: instr=0xFE000EE3, pc=0x100 -> imm=0xFFFFFFFC, target=0x000000FC. J-type: instr=0x0080006F, pc=0x100 -> imm=0x8, target=0x108.
- XLEN=64 U-type: instr=0x80000037 -> imm=0xFFFFFFFF80000000. SHAMT: instr=0x03F01013 -> imm=0x3F (XLEN=32 gives 0x1F).
- Backpressure: stream 4 I-types with out_ready=0 for 3 cycles -> in_ready drops after 2 accepts, outputs held stable, all 4 delivered in order once ready, no loss or duplication.
- Flush with both stages full and in_valid=1 -> next cycle out_valid=0, in_ready=1, and none of the three items ever appear.
- Illegal ext_op=6'b000011 -> imm=0, imm_err=1. Reset asserted mid-stream -> all outputs 0 on the next edge. With IMM_CSR_EN, instr=0x000FD073 and ext_op=CSR -> imm=0x1F.
